// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_pkg
// Purpose  : AHB-Lite transfer encodings, response codes and slave FSM states
// Revision : 1.0
// ============================================================================
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_XFER = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian lane mask for an aligned transfer of the given size.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_core.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_core
// Purpose  : word-wide storage array, byte-enable synchronous write, async read
// Revision : 1.0
// ============================================================================
module ahb_sram_core #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Purpose  : AHB-Lite memory responder with wait states, byte lanes and ERROR
// Revision : 1.0
// ============================================================================
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          c_addr_w    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_base      = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_limit     = c_base + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e        r_state, w_state_nxt;
    logic [3:0]          r_wait_cnt, w_wait_nxt;
    logic [c_addr_w-1:0] r_addr_idx;
    logic [3:0]          r_be;
    logic                r_write;

    logic                w_ready_out, w_take, w_err, w_misaligned, w_in_range;
    logic [c_addr_w-1:0] w_word_idx;
    logic [31:0]         w_rdata;
    logic                w_unused_ok;

    assign w_unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign w_ready_out = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign w_take      = HSEL && HREADY && HTRANS[1] && w_ready_out;
    assign w_in_range  = ({1'b0, HADDR} >= c_base) && ({1'b0, HADDR} < c_limit);
    assign w_word_idx  = c_addr_w'((HADDR - BASE_ADDR) >> 2);
    assign w_err       = !w_in_range || w_misaligned;

    // HSIZE above word width is reported as misaligned so it shares the error path.
    always_comb begin
        w_misaligned = 1'b0;
        case (HSIZE)
            HSIZE_BYTE: w_misaligned = 1'b0;
            HSIZE_HALF: w_misaligned = HADDR[0];
            HSIZE_WORD: w_misaligned = |HADDR[1:0];
            default:    w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_XFER;
                end else begin
                    w_wait_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_take) begin
            if (w_err) begin
                w_state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                w_state_nxt = ST_WAIT;
                w_wait_nxt  = c_wait_init;
            end else begin
                w_state_nxt = ST_XFER;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr_idx <= '0;
            r_be       <= 4'd0;
            r_write    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_take) begin
                r_addr_idx <= w_word_idx;
                r_be       <= byte_enable(HSIZE, HADDR[1:0]);
                r_write    <= HWRITE && !w_err;
            end
        end
    end

    // Writes land on the closing edge of XFER, so a following read of the same word sees them.
    ahb_sram_core #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_addr_w)
    ) u_core (
        .clk     (HCLK),
        .i_we    ((r_state == ST_XFER) && r_write),
        .i_be    (r_be),
        .i_addr  (r_addr_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HREADYOUT = w_ready_out;
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (r_state == ST_XFER) ? w_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_mem_slave
// Purpose  : directed bench for ahb_lite_mem_slave (zero-wait and two-wait instances)
// Revision : 1.0
// ============================================================================
module tb_ahb_lite_mem_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel;
    int          tgt;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;

    logic        sel0, sel1, rdy0, rdy1, resp0, resp1, rdy, resp;
    logic [31:0] rdata0, rdata1, rdata;
    int          vectors, miscompares;

    always #5 HCLK = ~HCLK;

    assign sel0  = hsel && (tgt == 0);
    assign sel1  = hsel && (tgt == 1);
    assign rdy   = (tgt == 0) ? rdy0   : rdy1;
    assign resp  = (tgt == 0) ? resp0  : resp1;
    assign rdata = (tgt == 0) ? rdata0 : rdata1;

    ahb_lite_mem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(rdy0), .HWDATA(hwdata), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb_lite_mem_slave #(.DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h1000)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(rdy1), .HWDATA(hwdata), .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] trans, input logic [31:0] addr,
                              input logic wr, input logic [2:0] size);
        hsel   = 1'b1;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd2;
    endtask

    // Leaves the caller at the negedge of the first ready data-phase cycle.
    task automatic wait_ready();
        bit done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge HCLK);
            if (rdy === 1'b1) done = 1'b1;
            else tick();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: HREADYOUT=%b, required 1 within 20 cycles", rdy);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        addr_phase(2'b10, addr, 1'b1, size);
        tick();
        bus_idle();
        hwdata = data;
        wait_ready();
        tick();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        addr_phase(2'b10, addr, 1'b0, 3'd2);
        tick();
        bus_idle();
        wait_ready();
        data = rdata;
        tick();
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        #3;
        HRESETn = 1'b0;
        #2;
        vectors++; if (rdy0 !== 1'b1)    begin miscompares++; $display("FAIL reset_ready0: got %b want 1", rdy0); end
        vectors++; if (resp0 !== 1'b0)   begin miscompares++; $display("FAIL reset_resp0: got %b want 0", resp0); end
        vectors++; if (rdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
        vectors++; if (rdy1 !== 1'b1)    begin miscompares++; $display("FAIL reset_ready1: got %b want 1", rdy1); end
        vectors++; if (resp1 !== 1'b0)   begin miscompares++; $display("FAIL reset_resp1: got %b want 0", resp1); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        vectors++; if (rdy0 !== 1'b1)  begin miscompares++; $display("FAIL idle_ready0: got %b want 1", rdy0); end
        vectors++; if (resp0 !== 1'b0) begin miscompares++; $display("FAIL idle_resp0: got %b want 0", resp0); end
        tick();
    endtask

    task automatic test_word_rw();
        tgt = 0;
        addr_phase(2'b10, 32'h10, 1'b1, 3'd2);
        tick();
        hwdata = 32'hDEADBEEF;
        addr_phase(2'b10, 32'h10, 1'b0, 3'd2);
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1)  begin miscompares++; $display("FAIL wr_ready: got %b want 1", rdy); end
        vectors++; if (resp !== 1'b0) begin miscompares++; $display("FAIL wr_resp: got %b want 0", resp); end
        tick();
        bus_idle();
        hwdata = 32'h0;
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1)          begin miscompares++; $display("FAIL rd_ready: got %b want 1", rdy); end
        vectors++; if (resp !== 1'b0)         begin miscompares++; $display("FAIL rd_resp: got %b want 0", resp); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
        tick();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        tgt = 0;
        bus_write(32'h10, 3'd2, 32'h0);
        bus_write(32'h13, 3'd0, 32'hA5112233);
        bus_read(32'h10, d);
        vectors++; if (d !== 32'hA5000000) begin miscompares++; $display("FAIL byte3: got %h want a5000000", d); end
        bus_write(32'h14, 3'd2, 32'h0);
        bus_write(32'h16, 3'd1, 32'h12345678);
        bus_read(32'h14, d);
        vectors++; if (d !== 32'h12340000) begin miscompares++; $display("FAIL half_hi: got %h want 12340000", d); end
        bus_write(32'h18, 3'd2, 32'hFFFFFFFF);
        bus_write(32'h19, 3'd0, 32'h00003C00);
        bus_read(32'h18, d);
        vectors++; if (d !== 32'hFFFF3CFF) begin miscompares++; $display("FAIL byte1: got %h want ffff3cff", d); end
        bus_write(32'h18, 3'd1, 32'h9999ABCD);
        bus_read(32'h18, d);
        vectors++; if (d !== 32'hFFFFABCD) begin miscompares++; $display("FAIL half_lo: got %h want ffffabcd", d); end
    endtask

    task automatic test_burst_busy();
        logic [31:0] d;
        logic [31:0] exp_data [3] = '{32'd1, 32'd2, 32'd3};
        tgt    = 0;
        hburst = 3'b001;
        addr_phase(2'b10, 32'h40, 1'b1, 3'd2);
        tick();
        hwdata = 32'd1;
        addr_phase(2'b11, 32'h44, 1'b1, 3'd2);
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL burst_dp1_ready: got %b want 1", rdy); end
        tick();
        hwdata = 32'd2;
        addr_phase(2'b01, 32'h48, 1'b1, 3'd2);
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL burst_dp2_ready: got %b want 1", rdy); end
        tick();
        hwdata = 32'hFFFFFFFF;
        addr_phase(2'b11, 32'h48, 1'b1, 3'd2);
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1)  begin miscompares++; $display("FAIL busy_ready: got %b want 1", rdy); end
        vectors++; if (resp !== 1'b0) begin miscompares++; $display("FAIL busy_resp: got %b want 0", resp); end
        tick();
        hwdata = 32'd3;
        bus_idle();
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL burst_dp3_ready: got %b want 1", rdy); end
        tick();
        hburst = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bus_read(32'h40 + 32'(4 * i), d);
            vectors++;
            if (d !== exp_data[i]) begin
                miscompares++;
                $display("FAIL burst_mem[%0d]: got %h want %h", i, d, exp_data[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [31:0] e_addr [4] = '{32'h2, 32'h1000, 32'h20, 32'h5};
        logic        e_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  e_size [4] = '{3'd2, 3'd2, 3'd3, 3'd1};
        tgt = 0;
        bus_write(32'h0,  3'd2, 32'h11111111);
        bus_write(32'h4,  3'd2, 32'h22222222);
        bus_write(32'h20, 3'd2, 32'h33333333);
        for (int i = 0; i < 4; i++) begin
            addr_phase(2'b10, e_addr[i], e_wr[i], e_size[i]);
            tick();
            bus_idle();
            hwdata = 32'hBAD0BAD0;
            @(negedge HCLK);
            vectors++; if (rdy !== 1'b0)  begin miscompares++; $display("FAIL err%0d_c1_ready: got %b want 0", i, rdy); end
            vectors++; if (resp !== 1'b1) begin miscompares++; $display("FAIL err%0d_c1_resp: got %b want 1", i, resp); end
            tick();
            @(negedge HCLK);
            vectors++; if (rdy !== 1'b1)  begin miscompares++; $display("FAIL err%0d_c2_ready: got %b want 1", i, rdy); end
            vectors++; if (resp !== 1'b1) begin miscompares++; $display("FAIL err%0d_c2_resp: got %b want 1", i, resp); end
            tick();
        end
        bus_read(32'h0, d);
        vectors++; if (d !== 32'h11111111) begin miscompares++; $display("FAIL err_mem0: got %h want 11111111", d); end
        bus_read(32'h4, d);
        vectors++; if (d !== 32'h22222222) begin miscompares++; $display("FAIL err_mem4: got %h want 22222222", d); end
        bus_read(32'h20, d);
        vectors++; if (d !== 32'h33333333) begin miscompares++; $display("FAIL err_mem20: got %h want 33333333", d); end
    endtask

    task automatic test_wait_states();
        logic [1:0] exp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tgt = 1;
        bus_write(32'h1008, 3'd2, 32'hCAFEF00D);
        addr_phase(2'b10, 32'h1008, 1'b0, 3'd2);
        tick();
        // the next read stays on the bus until the slave is ready
        for (int c = 0; c < 6; c++) begin
            if (c == 3) bus_idle();
            @(negedge HCLK);
            vectors++;
            if (rdy !== exp_rdy[c][0]) begin
                miscompares++;
                $display("FAIL ws_c%0d_ready: got %b want %b", c, rdy, exp_rdy[c][0]);
            end
            vectors++;
            if (rdata !== (exp_rdy[c][0] ? 32'hCAFEF00D : 32'h0)) begin
                miscompares++;
                $display("FAIL ws_c%0d_rdata: got %h want %h", c, rdata, exp_rdy[c][0] ? 32'hCAFEF00D : 32'h0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        tgt = 1;
        bus_write(32'h1010, 3'd2, 32'h55555555);
        addr_phase(2'b10, 32'h1010, 1'b1, 3'd2);
        tick();
        bus_idle();
        hwdata = 32'hAAAAAAAA;
        @(negedge HCLK);
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL rstw_pre_ready: got %b want 0", rdy); end
        #1;
        HRESETn = 1'b0;
        #1;
        vectors++; if (rdy !== 1'b1)     begin miscompares++; $display("FAIL rstw_ready: got %b want 1", rdy); end
        vectors++; if (resp !== 1'b0)    begin miscompares++; $display("FAIL rstw_resp: got %b want 0", resp); end
        vectors++; if (rdata !== 32'h0)  begin miscompares++; $display("FAIL rstw_rdata: got %h want 0", rdata); end
        tick();
        HRESETn = 1'b1;
        tick();
        bus_read(32'h1010, d);
        vectors++; if (d !== 32'h55555555) begin miscompares++; $display("FAIL rstw_mem: got %h want 55555555", d); end
        tgt = 0;
        bus_read(32'h10, d);
        vectors++; if (d !== 32'hA5000000) begin miscompares++; $display("FAIL rstw_mem0: got %h want a5000000", d); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        tgt         = 0;
        hburst      = 3'b000;
        hprot       = 4'b0011;
        hmastlock   = 1'b0;
        hwdata      = 32'h0;
        bus_idle();
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_burst_busy();
        test_errors();
        test_wait_states();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
